// File: rtl/fsk_240314.sv
// Free-running continuous-phase binary FSK generator: a PRBS7 bit stream picks
// one of two DDS tuning words, and the phase accumulator drives a quarter-wave sine LUT.
module fsk_240314 #(
    parameter logic [31:0] FTW0       = 32'd85899346,
    parameter logic [31:0] FTW1       = 32'd171798692,
    parameter int          BIT_CYCLES = 200,
    parameter logic [6:0]  PRBS_SEED  = 7'h7F
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    output logic [7:0] fsk_out,
    output logic       data_bit,
    output logic       bit_strobe
);

    localparam int                CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [31:0]      phaseAcc_q, phaseAcc_d;
    logic [7:0]       fsk_q, fsk_d;

    logic       lastCycle;
    logic [7:0] lutAddr;
    logic [6:0] lutLower;
    logic [6:0] lutIdx;
    logic [6:0] lutMag;

    // Q[k] = round(127*sin(2*pi*k/256)), k = 0..64
    function automatic logic [6:0] quarterSine(input logic [6:0] k);
        logic [6:0] q;
        case (k)
            7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
            7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
            7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
            7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
            7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
            7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
            7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
            7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
            7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
            7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
            7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
            7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
            7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
            7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
            default: q = 7'd127;
        endcase
        return q;
    endfunction

    assign lastCycle  = (bitCnt_q == LAST);
    assign bit_strobe = lastCycle;
    assign data_bit   = lfsr_q[6];
    assign fsk_out    = fsk_q;

    // Fold the 8-bit phase into the first quadrant; the upper half negates the magnitude.
    always_comb begin
        lutAddr  = phaseAcc_q[31:24];
        lutLower = lutAddr[6:0];
        lutIdx   = (lutLower > 7'd64) ? (7'd0 - lutLower) : lutLower;
        lutMag   = quarterSine(lutIdx);
        fsk_d    = lutAddr[7] ? (8'd128 - {1'b0, lutMag}) : (8'd128 + {1'b0, lutMag});
    end

    always_comb begin
        bitCnt_d   = lastCycle ? '0 : bitCnt_q + 1'b1;
        lfsr_d     = lastCycle ? {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]} : lfsr_q;
        phaseAcc_d = phaseAcc_q + (data_bit ? FTW1 : FTW0);
    end

    // The accumulator is never cleared between bits, so the phase stays continuous.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bitCnt_q   <= '0;
            lfsr_q     <= PRBS_SEED;
            phaseAcc_q <= 32'd0;
            fsk_q      <= 8'd128;
        end else begin
            bitCnt_q   <= bitCnt_d;
            lfsr_q     <= lfsr_d;
            phaseAcc_q <= phaseAcc_d;
            fsk_q      <= fsk_d;
        end
    end

endmodule

// File: tb/tb_fsk_240314.sv
// Directed bench for fsk_240314: three instances share one clock and reset,
// a fast-bit one (4 clocks/bit), a slow-bit one (100 clocks/bit) and one with defaults.
module tb_fsk_240314;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] fskA, fskB, fskC;
    logic       bitA, bitB, bitC;
    logic       strbA, strbB, strbC;

    int nChecks = 0;
    int nFails  = 0;

    int         markTab [16] = '{128, 177, 218, 245, 255, 245, 218, 177,
                                 128,  79,  38,  11,   1,  11,  38,  79};
    logic [8:0] bitsExp = 9'b0_0111_1111;

    fsk_240314 #(.FTW0(32'h0400_0000), .FTW1(32'h1000_0000), .BIT_CYCLES(4), .PRBS_SEED(7'h7F))
        dutA (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fsk_out(fskA), .data_bit(bitA), .bit_strobe(strbA));

    fsk_240314 #(.FTW0(32'h0400_0000), .FTW1(32'h1000_0000), .BIT_CYCLES(100), .PRBS_SEED(7'h7F))
        dutB (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fsk_out(fskB), .data_bit(bitB), .bit_strobe(strbB));

    fsk_240314 dutC (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fsk_out(fskC), .data_bit(bitC), .bit_strobe(strbC));

    always #5 sys_clk = ~sys_clk;

    // Direct-form reference: 128 + round(127*sin(2*pi*a/256)).
    function automatic int sineRef(input int a);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 256.0);
        if (r >= 0.0) return 128 + $rtoi(r + 0.5);
        else          return 128 - $rtoi(0.5 - r);
    endfunction

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge sys_clk);
        nChecks++;
        if (fskA !== 8'd128) begin nFails++; $display("[TB] FAIL reset_fsk got %0d expected 128", fskA); end
        nChecks++;
        if (bitA !== 1'b1) begin nFails++; $display("[TB] FAIL reset_data_bit got %b expected 1", bitA); end
        nChecks++;
        if (strbA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_strobe got %b expected 0", strbA); end
        nChecks++;
        if (dutA.phaseAcc_q !== 32'd0) begin nFails++; $display("[TB] FAIL reset_phase got %h expected 0", dutA.phaseAcc_q); end
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        nChecks++;
        if (dutA.phaseAcc_q !== 32'h1000_0000) begin nFails++; $display("[TB] FAIL first_phase_A got %h expected 10000000", dutA.phaseAcc_q); end
        nChecks++;
        if (dutC.phaseAcc_q !== 32'd171798692) begin nFails++; $display("[TB] FAIL first_phase_C got %0d expected 171798692", dutC.phaseAcc_q); end
        @(posedge sys_clk); #1;
        nChecks++;
        if (dutC.phaseAcc_q !== 32'd343597384) begin nFails++; $display("[TB] FAIL second_phase_C got %0d expected 343597384", dutC.phaseAcc_q); end
    endtask

    task automatic test_bit_timer();
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            @(posedge sys_clk); #1;
            nChecks++;
            if (strbA !== ((k % 4) == 3)) begin
                nFails++; $display("[TB] FAIL strobe edge %0d got %b expected %b", k, strbA, (k % 4) == 3);
            end
            nChecks++;
            if (bitA !== bitsExp[k / 4]) begin
                nFails++; $display("[TB] FAIL data_bit edge %0d got %b expected %b", k, bitA, bitsExp[k / 4]);
            end
        end
    endtask

    task automatic test_mark_tone();
        int maxV, minV;
        maxV = 0; minV = 255;
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            @(posedge sys_clk); #1;
            nChecks++;
            if (int'(fskB) !== markTab[(k - 1) % 16]) begin
                nFails++; $display("[TB] FAIL mark_tone edge %0d got %0d expected %0d", k, fskB, markTab[(k - 1) % 16]);
            end
            if (int'(fskB) > maxV) maxV = int'(fskB);
            if (int'(fskB) < minV) minV = int'(fskB);
        end
        nChecks++;
        if (maxV !== 255) begin nFails++; $display("[TB] FAIL mark_max got %0d expected 255", maxV); end
        nChecks++;
        if (minV !== 1) begin nFails++; $display("[TB] FAIL mark_min got %0d expected 1", minV); end
    endtask

    task automatic test_space_tone();
        int maxV, minV, expV;
        maxV = 0; minV = 255;
        do_reset();
        for (int k = 1; k <= 828; k++) begin
            @(posedge sys_clk); #1;
            if (k == 700) begin
                nChecks++;
                if (bitB !== 1'b0) begin nFails++; $display("[TB] FAIL space_bit got %b expected 0", bitB); end
            end
            if (k >= 701) begin
                expV = sineRef((192 + 4 * (k - 701)) % 256);
                nChecks++;
                if (int'(fskB) !== expV) begin
                    nFails++; $display("[TB] FAIL space_tone edge %0d got %0d expected %0d", k, fskB, expV);
                end
                if (int'(fskB) > maxV) maxV = int'(fskB);
                if (int'(fskB) < minV) minV = int'(fskB);
            end
        end
        nChecks++;
        if (maxV !== 255) begin nFails++; $display("[TB] FAIL space_max got %0d expected 255", maxV); end
        nChecks++;
        if (minV !== 1) begin nFails++; $display("[TB] FAIL space_min got %0d expected 1", minV); end
    endtask

    task automatic test_phase_continuity();
        logic [31:0] phaseExp [4] = '{32'hB000_0000, 32'hC000_0000, 32'hC400_0000, 32'hC800_0000};
        int f29, diff;
        f29 = 0;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            @(posedge sys_clk); #1;
            if (k >= 27) begin
                nChecks++;
                if (dutA.phaseAcc_q !== phaseExp[k - 27]) begin
                    nFails++; $display("[TB] FAIL phase_cont edge %0d got %h expected %h", k, dutA.phaseAcc_q, phaseExp[k - 27]);
                end
            end
            if (k == 28) begin
                nChecks++;
                if (bitA !== 1'b0) begin nFails++; $display("[TB] FAIL boundary_bit got %b expected 0", bitA); end
            end
            if (k == 29) begin
                f29 = int'(fskA);
                nChecks++;
                if (fskA !== 8'd1) begin nFails++; $display("[TB] FAIL boundary_fsk29 got %0d expected 1", fskA); end
            end
            if (k == 30) begin
                nChecks++;
                if (fskA !== 8'd2) begin nFails++; $display("[TB] FAIL boundary_fsk30 got %0d expected 2", fskA); end
                diff = int'(fskA) - f29;
                if (diff < 0) diff = -diff;
                nChecks++;
                if (diff > 49) begin nFails++; $display("[TB] FAIL boundary_step got %0d expected <= 49", diff); end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (31) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        nChecks++;
        if (fskA !== 8'd128) begin nFails++; $display("[TB] FAIL async_fsk got %0d expected 128", fskA); end
        nChecks++;
        if (bitA !== 1'b1) begin nFails++; $display("[TB] FAIL async_data_bit got %b expected 1", bitA); end
        nChecks++;
        if (strbA !== 1'b0) begin nFails++; $display("[TB] FAIL async_strobe got %b expected 0", strbA); end
        nChecks++;
        if (dutA.phaseAcc_q !== 32'd0) begin nFails++; $display("[TB] FAIL async_phase got %h expected 0", dutA.phaseAcc_q); end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge sys_clk); #1;
            nChecks++;
            if (dutA.phaseAcc_q !== (32'(k) << 28)) begin
                nFails++; $display("[TB] FAIL rerun_phase edge %0d got %h expected %h", k, dutA.phaseAcc_q, 32'(k) << 28);
            end
            nChecks++;
            if (strbA !== ((k % 4) == 3)) begin
                nFails++; $display("[TB] FAIL rerun_strobe edge %0d got %b expected %b", k, strbA, (k % 4) == 3);
            end
            nChecks++;
            if (bitA !== bitsExp[k / 4]) begin
                nFails++; $display("[TB] FAIL rerun_data_bit edge %0d got %b expected %b", k, bitA, bitsExp[k / 4]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_bit_timer();
        test_mark_tone();
        test_space_tone();
        test_phase_continuity();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
